mdu_ctrl: RTL
=============

// Module: mdu_ctrl
// PURPOSE
//  Sequences the multiply/divide unit beside the E-stage ALU; owns the architectural HI/LO registers.
//  Accepts mult/multu/div/divu/mthi/mtlo from E and models multi-cycle latency with a busy counter.
//  Generates the D-stage stall for any HI/LO-using instruction while the unit is occupied.
//  Honours the P7 exception/interrupt flush: an MD op flushed in its E cycle never starts.
// PARAMETERS
//  MULT_CYC  5   busy cycles for mult/multu (>=1)
//  DIV_CYC   10  busy cycles for div/divu (>=1)
// PORTS
//  clk       in   1   rising-edge clock
//  reset_n   in   1   asynchronous, active-low reset
//  start     in   1   E-stage instr is mult/multu/div/divu (valid)
//  md_op     in   2   0 mult, 1 multu, 2 div, 3 divu
//  rs        in   32  forwarded RS operand (E)
//  rt        in   32  forwarded RT operand (E)
//  mthi      in   1   E-stage mthi
//  mtlo      in   1   E-stage mtlo
//  flush     in   1   exception/interrupt taken this cycle; squashes E-stage start/mthi/mtlo
//  md_use_d  in   1   D-stage instr reads/writes HI/LO or starts MD op
//  busy      out  1   unit occupied (counting)
//  stall_md  out  1   = md_use_d & (start | busy), combinational
//  hi        out  32  HI register
//  lo        out  32  LO register
// BEHAVIOUR
//  - Reset: busy=0, count=0, hi=0, lo=0, state IDLE; async assert, sync-safe release. Reset mid-op aborts, no HI/LO write.
//  - FSM: IDLE --(start & ~flush & ~busy)--> RUN; RUN --(count==1)--> IDLE. busy=1 exactly in RUN.
//  - Start at edge T: operands + op latched; count loads MULT_CYC or DIV_CYC; busy high cycles T+1..T+N.
//  - Commit: at edge ending cycle T+N, hi/lo take the result; new value visible same cycle busy falls.
//  - mult: {hi,lo}=$signed(rs)*$signed(rt) (64b). multu: unsigned 64b product.
//  - div: lo=signed quotient truncated toward zero, hi=remainder with dividend sign. divu: unsigned.
//  - Divide by zero (rt==0): op runs full DIV_CYC, hi/lo left unchanged; no exception.
//  - Overflow div 0x80000000/-1: lo=0x80000000, hi=0.
//  - mthi/mtlo: write rs into hi/lo at next edge if ~flush & ~busy; ignored while busy (pipeline guarantees stall).
//  - start while busy: ignored (protocol violation; stall_md prevents it). start & mthi same cycle: start wins.
//  - flush: squashes start/mthi/mtlo of same cycle only; an op already in RUN completes and commits.
//  - stall_md covers the start cycle itself (start=1) so D cannot issue mfhi/mflo before busy rises.
//  - hi/lo are pure register outputs; no bypass of in-flight results.
// STRUCTURE
//  - macro.v gains: MD_MULT/MD_MULTU/MD_DIV/MD_DIVU op codes, default cycle counts.
//  - One sub-module md_arith: combinational, {op, a, b} -> {hi_n, lo_n, dz}; evaluated on latched operands.
//  - mdu_ctrl holds FSM, counter (width $clog2(max(MULT_CYC,DIV_CYC))+1), operand latches, HI/LO.
// TESTING
//  - mult rs=0xFFFFFFFF rt=2 -> busy 5 cycles, then hi=0xFFFFFFFF lo=0xFFFFFFFE.
//  - multu same operands -> hi=0x00000001 lo=0xFFFFFFFE after 5 busy cycles.
//  - div rs=-7 rt=2 -> busy 10 cycles, lo=0xFFFFFFFD hi=0xFFFFFFFF; divu 7/0 -> hi/lo unchanged.
//  - start=1 with flush=1 -> busy stays 0, hi/lo unchanged; mthi rs=0x1234 with flush -> hi unchanged.
//  - md_use_d=1 during start cycle and all busy cycles -> stall_md=1; drops the cycle busy falls.
//  - reset_n low in 3rd busy cycle of div -> busy=0, hi=lo=0 immediately; no later commit.

Source files
------------

// File: rtl/mdu_ctrl_pkg.sv
// Shared definitions for the multiply/divide unit controller.
// Holds the MD operation codes, FSM state encoding, default busy-cycle
// counts and small elaboration helpers used by mdu_ctrl and md_arith.
package mdu_ctrl_pkg;

  // Operation codes carried on md_op.
  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } md_op_e;

  // Sequencer states; busy is asserted exactly in ST_RUN.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  localparam int MD_MULT_CYC_DEF = 5;
  localparam int MD_DIV_CYC_DEF  = 10;

  // Larger of two elaboration-time integers (sizes the busy counter).
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Divide ops share the upper opcode bit.
  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational multiply/divide datapath.
// Ports:
//   op_i  [1:0]  operation code (md_op_e encoding)
//   a_i   [31:0] dividend / multiplicand (latched RS)
//   b_i   [31:0] divisor / multiplier (latched RT)
//   hi_o  [31:0] high product word or remainder
//   lo_o  [31:0] low product word or quotient
//   dz_o         divide op with zero divisor; result must be discarded
module md_arith
  import mdu_ctrl_pkg::*;
(
  input  logic [1:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        dz_o
);

  logic [63:0] prod_s;

  // Result selection for all four operations.
  always_comb begin
    prod_s = 64'd0;
    hi_o   = 32'd0;
    lo_o   = 32'd0;
    dz_o   = 1'b0;
    case (op_i)
      MD_MULT: begin
        prod_s = $signed({{32{a_i[31]}}, a_i}) * $signed({{32{b_i[31]}}, b_i});
        hi_o   = prod_s[63:32];
        lo_o   = prod_s[31:0];
      end
      MD_MULTU: begin
        prod_s = {32'd0, a_i} * {32'd0, b_i};
        hi_o   = prod_s[63:32];
        lo_o   = prod_s[31:0];
      end
      MD_DIV: begin
        if (b_i == 32'd0) begin
          dz_o = 1'b1;
        end else if ((a_i == 32'h8000_0000) && (b_i == 32'hFFFF_FFFF)) begin
          // Most-negative / -1 overflows; pin the architectural result.
          lo_o = 32'h8000_0000;
          hi_o = 32'd0;
        end else begin
          lo_o = $signed(a_i) / $signed(b_i);
          hi_o = $signed(a_i) % $signed(b_i);
        end
      end
      MD_DIVU: begin
        if (b_i == 32'd0) begin
          dz_o = 1'b1;
        end else begin
          lo_o = a_i / b_i;
          hi_o = a_i % b_i;
        end
      end
      default: begin
        dz_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide unit sequencer beside the E-stage ALU; owns HI/LO.
// An accepted op latches its operands, occupies the unit for MULT_CYC or
// DIV_CYC cycles, then commits into HI/LO on the edge where busy falls.
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   start, md_op        E-stage MD op request and its code
//   rs, rt              forwarded E-stage operands
//   mthi, mtlo          E-stage writes of rs into HI/LO
//   flush               squashes this cycle's start/mthi/mtlo
//   md_use_d            D-stage instruction touches HI/LO or the unit
//   busy                unit occupied
//   stall_md            D-stage stall request (combinational)
//   hi, lo              architectural HI/LO registers
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int MULT_CYC = MD_MULT_CYC_DEF,
  parameter int DIV_CYC  = MD_DIV_CYC_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [1:0]  md_op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic        flush,
  input  logic        md_use_d,
  output logic        busy,
  output logic        stall_md,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CNT_W = $clog2(max_int(MULT_CYC, DIV_CYC)) + 1;
  localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYC);
  localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       op_q;
  logic [31:0]      a_q, b_q;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic [31:0]      hi_n_s, lo_n_s;
  logic             dz_s, accept_s, done_s, mthi_ok_s, mtlo_ok_s;

  // A start is only taken from IDLE, and a flush kills it.
  assign accept_s  = start & ~flush & (state_q == ST_IDLE);
  assign done_s    = (state_q == ST_RUN) && (cnt_q == CNT_ONE);
  // Moves lose to a same-cycle start and are dropped while occupied.
  assign mthi_ok_s = mthi & ~flush & ~start & (state_q == ST_IDLE);
  assign mtlo_ok_s = mtlo & ~flush & ~start & (state_q == ST_IDLE);

  md_arith u_arith (
    .op_i (op_q),
    .a_i  (a_q),
    .b_i  (b_q),
    .hi_o (hi_n_s),
    .lo_o (lo_n_s),
    .dz_o (dz_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept_s) state_d = ST_RUN;  else state_d = ST_IDLE;
      ST_RUN:  if (done_s)   state_d = ST_IDLE; else state_d = ST_RUN;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs; the stall also covers the start cycle before busy rises.
  always_comb begin
    busy     = (state_q == ST_RUN);
    stall_md = md_use_d & (start | (state_q == ST_RUN));
  end

  // Busy counter and HI/LO next values.
  always_comb begin
    cnt_d = cnt_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
    if (accept_s) cnt_d = op_is_div(md_op) ? DIV_LD : MULT_LD;
    else if (state_q == ST_RUN) cnt_d = cnt_q - CNT_ONE;
    else cnt_d = cnt_q;
    // Divide by zero runs the full latency but leaves HI/LO alone.
    if (done_s && !dz_s) begin
      hi_d = hi_n_s;
      lo_d = lo_n_s;
    end else begin
      if (mthi_ok_s) hi_d = rs; else hi_d = hi_q;
      if (mtlo_ok_s) lo_d = rs; else lo_d = lo_q;
    end
  end

  // Counter and HI/LO registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      hi_q  <= 32'd0;
      lo_q  <= 32'd0;
    end else begin
      cnt_q <= cnt_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
    end
  end

  // Operand and opcode latches, captured when an op is accepted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q <= 2'd0;
      a_q  <= 32'd0;
      b_q  <= 32'd0;
    end else if (accept_s) begin
      op_q <= md_op;
      a_q  <= rs;
      b_q  <= rt;
    end else begin
      op_q <= op_q;
      a_q  <= a_q;
      b_q  <= b_q;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule
